pwm_multichannel: RTL and testbench

Parametrised multi-channel PWM generator. It replaces the single-channel increase/decrease-duty PWM block behind the Tiny Tapeout top-level wrapper. Two raw push-button inputs step the duty of one selected channel up or down, after synchronisation and debouncing. All channels share one period counter, which runs in either edge-aligned or centre-aligned mode, and duty values are double-buffered so a change never glitches the current period.

---
 rtl/pwm_pkg.sv | 9 +
 rtl/pwm_debounce.sv | 30 +++
 rtl/pwm_multichannel.sv | 97 +++++++++
 tb/tb_pwm_multichannel.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode encodings, counter direction type and channel-select width helper.
package pwm_pkg;
    localparam logic PWM_MODE_EDGE = 1'b0;
    localparam logic PWM_MODE_CENTER = 1'b1;
    typedef enum logic {UP, DOWN} dir_t;
    function automatic int sel_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction
endpackage

// File: rtl/pwm_debounce.sv
// pwm_debounce: two-flop synchroniser, stable-level debouncer and one-cycle rising-edge press pulse.
module pwm_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEB_CYCLES);
    logic [1:0] sync;
    logic stable;
    logic [CW-1:0] cnt;
    logic hit;
    assign hit = (sync[1] != stable) && (cnt == CW'(DEB_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            stable <= 1'b0;
            cnt <= '0;
            press_o <= 1'b0;
        end else begin
            sync <= {sync[0], btn_i};
            stable <= hit ? sync[1] : stable;
            // any agreement with the stable level restarts the count
            cnt <= (sync[1] == stable || hit) ? '0 : cnt + 1'b1;
            press_o <= hit & sync[1];
        end
    end
endmodule

// File: rtl/pwm_multichannel.sv
// pwm_multichannel: CH-channel PWM sharing one edge/centre-aligned counter, with
// double-buffered duties stepped by debounced inc/dec buttons on the selected channel.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int CH = 4,
    parameter int WIDTH = 8,
    parameter int STEP = 16,
    parameter int RESET_DUTY = 128,
    parameter int DEB_CYCLES = 50000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inc_i,
    input  logic                       dec_i,
    input  logic [sel_width(CH)-1:0]   ch_sel_i,
    input  logic                       mode_i,
    output logic [CH-1:0]              pwm_o,
    output logic [WIDTH-1:0]           duty_o,
    output logic                       period_o
);
    localparam logic [WIDTH-1:0] PMAX = '1;
    localparam logic [WIDTH-1:0] LAST = PMAX - 1'b1;
    localparam logic [WIDTH-1:0] RD = WIDTH'(RESET_DUTY);
    localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);
    logic inc_p, dec_p;
    logic [WIDTH-1:0] duty [CH];
    logic [WIDTH-1:0] shadow [CH];
    logic [WIDTH-1:0] shadow_n [CH];
    logic [CH-1:0] pwm_n;
    logic [WIDTH-1:0] cnt, cnt_n, cur, nxt;
    logic [WIDTH:0] up;
    dir_t dir, dir_n;
    logic mode, mode_eff, start, sel_ok, write;

    pwm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc (.clk(clk), .rst(rst), .btn_i(inc_i), .press_o(inc_p));
    pwm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dec (.clk(clk), .rst(rst), .btn_i(dec_i), .press_o(dec_p));

    assign sel_ok = int'(ch_sel_i) < CH;
    assign cur = sel_ok ? duty[ch_sel_i] : '0;
    assign duty_o = cur;
    assign up = {1'b0, cur} + STEP_W;
    assign nxt = inc_p ? ((up > {1'b0, PMAX}) ? PMAX : up[WIDTH-1:0])
                       : (({1'b0, cur} < STEP_W) ? '0 : cur - STEP_W[WIDTH-1:0]);
    // simultaneous inc and dec presses cancel
    assign write = sel_ok && (inc_p ^ dec_p);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            dir <= UP;
            mode <= PWM_MODE_EDGE;
        end else begin
            cnt <= cnt_n;
            dir <= dir_n;
            mode <= start ? mode_i : mode;
        end
    end

    always_comb begin
        mode_eff = start ? mode_i : mode;
        if (mode_eff == PWM_MODE_EDGE) begin
            dir_n = UP;
            cnt_n = (cnt == LAST) ? '0 : cnt + 1'b1;
        end else if (dir == UP) begin
            dir_n = (cnt == LAST) ? DOWN : UP;
            cnt_n = (cnt == LAST) ? cnt : cnt + 1'b1;
        end else begin
            dir_n = (cnt == '0) ? UP : DOWN;
            cnt_n = (cnt == '0) ? cnt : cnt - 1'b1;
        end
    end

    always_comb begin
        start = (cnt == '0) && (dir == UP);
        period_o = start && !rst;
        pwm_n = '0;
        for (int k = 0; k < CH; k++) begin
            // compare against the value being loaded so a new duty covers its whole period
            shadow_n[k] = start ? duty[k] : shadow[k];
            pwm_n[k] = cnt < shadow_n[k];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < CH; k++) begin
            if (rst) begin
                duty[k] <= RD;
                shadow[k] <= RD;
            end else begin
                if (write && k == int'(ch_sel_i)) duty[k] <= nxt;
                shadow[k] <= shadow_n[k];
            end
        end
        pwm_o <= rst ? '0 : pwm_n;
    end
endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: table-driven, hand-sequenced and randomized checks against a duty/period model.
module tb_pwm_multichannel;
    localparam int CH = 4;
    logic clk = 0, rst = 1, inc_i = 0, dec_i = 0, mode_i = 0;
    logic [1:0] ch_sel_i = 0;
    logic [CH-1:0] pwm_o;
    logic [7:0] duty_o;
    logic period_o;
    int errs = 0, checks = 0;

    typedef struct {
        logic [1:0] sel;
        bit inc;
        bit dec;
        int n;
        bit [31:0] exp;
    } vec_t;
    vec_t vecs[6];

    pwm_multichannel #(.CH(4), .WIDTH(8), .STEP(16), .RESET_DUTY(128), .DEB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .inc_i(inc_i), .dec_i(dec_i), .ch_sel_i(ch_sel_i),
        .mode_i(mode_i), .pwm_o(pwm_o), .duty_o(duty_o), .period_o(period_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic get_duty(input int k, output int d);
        ch_sel_i = 2'(k);
        #1 d = int'(duty_o);
    endtask

    task automatic do_reset();
        int d;
        @(negedge clk);
        rst = 1; inc_i = 0; dec_i = 0;
        @(negedge clk);
        check("rst_pwm", int'(pwm_o), 0);
        check("rst_period", int'(period_o), 0);
        for (int k = 0; k < CH; k++) begin
            get_duty(k, d);
            check("rst_duty", d, 128);
        end
        ch_sel_i = 0;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("first_period", int'(period_o), 1);
        @(negedge clk);
        check("first_pwm", int'(pwm_o), 15);
        check("second_period", int'(period_o), 0);
    endtask

    task automatic press(input int sel, input bit inc, input bit dec);
        @(negedge clk);
        ch_sel_i = 2'(sel); inc_i = inc; dec_i = dec;
        repeat (10) @(negedge clk);
        inc_i = 0; dec_i = 0;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_start();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_o && n < 1200);
        if (n >= 1200) begin
            errs++;
            $display("FAIL wait_start: no period_o within %0d cycles", n);
        end
    endtask

    // window runs from the cycle after one period_o to the next period_o inclusive,
    // so pwm_o (one stage behind the counter) covers exactly one period
    task automatic measure(output int len, output int hi[CH]);
        wait_start();
        len = 0;
        for (int k = 0; k < CH; k++) hi[k] = 0;
        do begin
            @(negedge clk);
            len++;
            for (int k = 0; k < CH; k++) hi[k] += int'(pwm_o[k]);
        end while (!period_o && len < 1200);
    endtask

    initial begin
        int d, len, n, old, sel, kind;
        int hi[CH];
        int md[CH];
        bit inc, dec;
        vecs[0] = '{2'd2, 1'b1, 1'b0, 9,  32'h80FF8080};
        vecs[1] = '{2'd1, 1'b0, 1'b1, 10, 32'h80FF0080};
        vecs[2] = '{2'd0, 1'b1, 1'b1, 2,  32'h80FF0080};
        vecs[3] = '{2'd3, 1'b1, 1'b0, 1,  32'h90FF0080};
        vecs[4] = '{2'd3, 1'b0, 1'b1, 3,  32'h60FF0080};
        vecs[5] = '{2'd0, 1'b0, 1'b1, 1,  32'h60FF0070};

        do_reset();
        measure(len, hi);
        check("edge_len", len, 255);
        for (int k = 0; k < CH; k++) check("edge_high", hi[k], 128);

        foreach (vecs[i]) begin
            for (int j = 0; j < vecs[i].n; j++) press(vecs[i].sel, vecs[i].inc, vecs[i].dec);
            for (int k = 0; k < CH; k++) begin
                get_duty(k, d);
                check($sformatf("vec%0d_ch%0d", i, k), d, int'(vecs[i].exp[8*k +: 8]));
            end
        end
        measure(len, hi);
        check("tbl_len", len, 255);
        check("tbl_high0", hi[0], 112);
        check("tbl_high1_low", hi[1], 0);
        check("tbl_high2_sat", hi[2], 255);
        check("tbl_high3", hi[3], 96);

        do_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            inc_i = ((i / 3) % 2) == 0;
        end
        check("bounce_none", int'(duty_o), 128);
        @(negedge clk);
        inc_i = 1;
        repeat (10) @(negedge clk);
        inc_i = 0;
        repeat (10) @(negedge clk);
        check("bounce_one", int'(duty_o), 144);

        @(negedge clk);
        old = int'(duty_o);
        inc_i = 1;
        n = 0;
        while (int'(duty_o) == old && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("press_latency", n, 7);
        repeat (3) @(negedge clk);
        inc_i = 0;
        repeat (8) @(negedge clk);
        check("latency_duty", int'(duty_o), 160);

        wait_start();
        for (int i = 1; i <= 170; i++) begin
            @(negedge clk);
            if (i == 5) inc_i = 1;
            if (i == 20) inc_i = 0;
        end
        check("hold_duty", int'(duty_o), 176);
        check("hold_old_pwm", int'(pwm_o[0]), 0);
        measure(len, hi);
        check("hold_new_high", hi[0], 176);

        md = '{176, 128, 128, 128};
        for (int r = 0; r < 12; r++) begin
            sel = $urandom_range(0, 3);
            kind = $urandom_range(0, 3);
            inc = (kind != 1);
            dec = (kind == 1 || kind == 2);
            press(sel, inc, dec);
            if (inc && !dec) md[sel] = (md[sel] + 16 > 255) ? 255 : md[sel] + 16;
            if (dec && !inc) md[sel] = (md[sel] < 16) ? 0 : md[sel] - 16;
            get_duty(sel, d);
            check("rand_duty", d, md[sel]);
        end
        measure(len, hi);
        check("rand_len", len, 255);
        for (int k = 0; k < CH; k++) check("rand_high", hi[k], md[k]);

        do_reset();
        for (int j = 0; j < 4; j++) press(0, 1'b0, 1'b1);
        check("c_duty", int'(duty_o), 64);
        mode_i = 1;
        measure(len, hi);
        check("centre_len", len, 510);
        check("centre_high0", hi[0], 128);
        for (int k = 1; k < CH; k++) check("centre_high", hi[k], 256);
        check("centre_edge0", int'(pwm_o[0]), 1);
        for (int i = 1; i <= 447; i++) begin
            @(negedge clk);
            if (i == 64) check("centre_up63", int'(pwm_o[0]), 1);
            if (i == 65) check("centre_up64", int'(pwm_o[0]), 0);
            if (i == 446) check("centre_dn64", int'(pwm_o[0]), 0);
            if (i == 447) check("centre_dn63", int'(pwm_o[0]), 1);
        end
        mode_i = 0;
        do_reset();
        measure(len, hi);
        check("post_rst_len", len, 255);
        for (int k = 0; k < CH; k++) check("post_rst_high", hi[k], 128);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
